// File: rtl/mult_stress_harness.sv
// rtl/mult_stress_harness.sv - multiplier stress harness: stimulus modes, optional product pipeline, golden self-check
// Wallace_Tree_Multiplier: carry-save reduction of partial products in layers of 3:2 compressors.

module Wallace_Tree_Multiplier #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] product
);
    localparam int P = 2 * N;

    function automatic int rows_at(input int layer);
        int n;
        n = N;
        for (int i = 0; i < layer; i++) n = 2 * (n / 3) + n % 3;
        return n;
    endfunction

    function automatic int layer_count();
        int n;
        int c;
        n = N;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            if (n > 2) begin
                n = 2 * (n / 3) + n % 3;
                c++;
            end
        end
        return c;
    endfunction

    localparam int LAYERS = layer_count();

    logic [P-1:0] rows [LAYERS+1][N];

    for (genvar i = 0; i < N; i++) begin : g_pp
        assign rows[0][i] = b[i] ? (P'(a) << i) : '0;
    end

    for (genvar l = 0; l < LAYERS; l++) begin : g_layer
        localparam int NI = rows_at(l);
        localparam int NG = NI / 3;
        localparam int NO = rows_at(l + 1);
        for (genvar g = 0; g < NG; g++) begin : g_csa
            assign rows[l+1][2*g]   = rows[l][3*g] ^ rows[l][3*g+1] ^ rows[l][3*g+2];
            assign rows[l+1][2*g+1] = ((rows[l][3*g] & rows[l][3*g+1]) |
                                       (rows[l][3*g] & rows[l][3*g+2]) |
                                       (rows[l][3*g+1] & rows[l][3*g+2])) << 1;
        end
        for (genvar k = 3 * NG; k < NI; k++) begin : g_pass
            assign rows[l+1][2*NG+k-3*NG] = rows[l][k];
        end
        for (genvar k = NO; k < N; k++) begin : g_zero
            assign rows[l+1][k] = '0;
        end
    end

    assign product = rows[LAYERS][0] + rows[LAYERS][1];
endmodule

module mult_stress_harness #(
    parameter int          WIDTH       = 8,
    parameter int          PIPE_STAGES = 0,
    parameter int          CNT_W       = 17,
    parameter logic [31:0] LFSR_SEED   = 32'h0000ACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   num_vectors,
    input  logic               inject_fault,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] sum,
    output logic               sum_valid,
    output logic [15:0]        err_count,
    output logic [WIDTH-1:0]   first_err_a,
    output logic [WIDTH-1:0]   first_err_b,
    output logic               pass
);
    localparam int PW  = 2 * WIDTH;
    localparam int LAT = PIPE_STAGES + 1;

    function automatic logic [PW-1:0] tap_mask();
        case (PW)
            4:       tap_mask = PW'(32'h0000000C);
            8:       tap_mask = PW'(32'h000000B8);
            12:      tap_mask = PW'(32'h00000829);
            16:      tap_mask = PW'(32'h0000B400);
            24:      tap_mask = PW'(32'h00E10000);
            32:      tap_mask = PW'(32'h80200003);
            default: tap_mask = PW'(2'b11) << (PW - 2);
        endcase
    endfunction

    localparam logic [PW-1:0] TAPS     = tap_mask();
    localparam logic [PW-1:0] SEED_RAW = PW'(LFSR_SEED);
    localparam logic [PW-1:0] SEED     = (SEED_RAW == '0) ? '1 : SEED_RAW;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_n;

    logic [1:0]       mode_q;
    logic [CNT_W-1:0] num_q, issued;
    logic [PW-1:0]    lfsr;
    logic [WIDTH-1:0] walk;
    logic [2:0]       drain_cnt;
    logic [WIDTH-1:0] a_q, b_q, gen_a, gen_b, chk_a, chk_b;
    logic [PW-1:0]    prod, prod_f, prod_last, gen_gold, gold_q;
    logic             accept, issue, mismatch;
    logic [15:0]      err_next;

    logic             ch_v [LAT];
    logic [WIDTH-1:0] ch_a [LAT];
    logic [WIDTH-1:0] ch_b [LAT];
    logic [PW-1:0]    ch_g [LAT];

    assign accept   = start && (state == S_IDLE || state == S_DONE);
    assign issue    = (state == S_RUN) && (issued != num_q);
    assign busy     = (state == S_RUN) || (state == S_DRAIN);
    assign done     = (state == S_DONE);
    assign mismatch = sum_valid && (sum != gold_q);
    assign err_next = (mismatch && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_RUN;
            S_RUN:   if (issued == num_q) state_n = (num_q == '0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (drain_cnt == 3'(LAT - 1)) state_n = S_DONE;
            S_DONE:  if (start) state_n = S_RUN;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        gen_a = '1;
        gen_b = '1;
        case (mode_q)
            2'd1:    {gen_a, gen_b} = lfsr;
            2'd2:    {gen_a, gen_b} = PW'(issued);
            2'd3:    gen_a = walk;
            default: ;
        endcase
    end

    assign gen_gold = {{WIDTH{1'b0}}, gen_a} * {{WIDTH{1'b0}}, gen_b};

    if (WIDTH == 8) begin : g_wallace
        Wallace_Tree_Multiplier #(.N(WIDTH)) u_mul (.a(a_q), .b(b_q), .product(prod));
    end else begin : g_behav
        assign prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    end

    // Fault injection sits ahead of the pipeline so the checker sees it like a real datapath error.
    assign prod_f = {prod[PW-1:1], prod[0] ^ inject_fault};

    if (PIPE_STAGES == 0) begin : g_nopipe
        assign prod_last = prod_f;
    end else begin : g_pipe
        logic [PW-1:0] pipe [PIPE_STAGES];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < PIPE_STAGES; i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= prod_f;
                for (int i = 1; i < PIPE_STAGES; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign prod_last = pipe[PIPE_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) begin
                ch_v[i] <= 1'b0;
                ch_a[i] <= '0;
                ch_b[i] <= '0;
                ch_g[i] <= '0;
            end
        end else begin
            ch_v[0] <= issue;
            ch_a[0] <= gen_a;
            ch_b[0] <= gen_b;
            ch_g[0] <= gen_gold;
            for (int i = 1; i < LAT; i++) begin
                ch_v[i] <= ch_v[i-1];
                ch_a[i] <= ch_a[i-1];
                ch_b[i] <= ch_b[i-1];
                ch_g[i] <= ch_g[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q      <= '0;
            num_q       <= '0;
            issued      <= '0;
            lfsr        <= SEED;
            walk        <= WIDTH'(1);
            drain_cnt   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum         <= '0;
            sum_valid   <= 1'b0;
            gold_q      <= '0;
            chk_a       <= '0;
            chk_b       <= '0;
            err_count   <= '0;
            first_err_a <= '0;
            first_err_b <= '0;
            pass        <= 1'b0;
        end else begin
            if (issue) begin
                a_q    <= gen_a;
                b_q    <= gen_b;
                issued <= issued + 1'b1;
                lfsr   <= {lfsr[PW-2:0], ^(lfsr & TAPS)};
                walk   <= {walk[WIDTH-2:0], walk[WIDTH-1]};
            end
            if (state == S_RUN)        drain_cnt <= '0;
            else if (state == S_DRAIN) drain_cnt <= drain_cnt + 3'd1;

            sum_valid <= ch_v[LAT-1];
            if (ch_v[LAT-1]) begin
                sum    <= prod_last;
                gold_q <= ch_g[LAT-1];
                chk_a  <= ch_a[LAT-1];
                chk_b  <= ch_b[LAT-1];
            end

            if (mismatch) begin
                err_count <= err_next;
                if (err_count == 16'd0) begin
                    first_err_a <= chk_a;
                    first_err_b <= chk_b;
                end
            end
            // err_next folds in the final compare, which lands on the same edge as DONE entry.
            if (state_n == S_DONE && state != S_DONE) pass <= (err_next == 16'd0);

            if (accept) begin
                mode_q      <= mode;
                num_q       <= num_vectors;
                issued      <= '0;
                lfsr        <= SEED;
                walk        <= WIDTH'(1);
                err_count   <= '0;
                first_err_a <= '0;
                first_err_b <= '0;
                pass        <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mult_stress_harness.sv
// tb/tb_mult_stress_harness.sv - scoreboard bench driving a Wallace (8-bit, no pipe) and a behavioural (4-bit, 2-stage) harness
module tb_mult_stress_harness;
    localparam int W0 = 8, P0 = 0, W1 = 4, P1 = 2, CW = 17;

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0, inject = 1'b0;
    logic [1:0]    mode = '0;
    logic [CW-1:0] num = '0;

    logic        busy0, done0, sv0, pass0, busy1, done1, sv1, pass1;
    logic [15:0] sum0, err0, err1;
    logic [7:0]  sum1, fa0, fb0;
    logic [3:0]  fa1, fb1;

    mult_stress_harness #(.WIDTH(W0), .PIPE_STAGES(P0), .CNT_W(CW)) dut0 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .num_vectors(num),
        .inject_fault(inject), .busy(busy0), .done(done0), .sum(sum0), .sum_valid(sv0),
        .err_count(err0), .first_err_a(fa0), .first_err_b(fb0), .pass(pass0));

    mult_stress_harness #(.WIDTH(W1), .PIPE_STAGES(P1), .CNT_W(CW)) dut1 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .num_vectors(num),
        .inject_fault(inject), .busy(busy1), .done(done1), .sum(sum1), .sum_valid(sv1),
        .err_count(err1), .first_err_a(fa1), .first_err_b(fb1), .pass(pass1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint s;
        int     c;
    } exp_t;

    exp_t   q0[$], q1[$];
    exp_t   e0, e1;
    int     checks = 0, errors = 0;
    longint exp_err[2], exp_fa[2], exp_fb[2], last_s[2];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic longint lfsr_step(input longint v, input int pw);
        int     taps[4];
        longint fb;
        if (pw == 16) taps = '{16, 14, 13, 11};
        else          taps = '{8, 6, 5, 4};
        fb = 0;
        foreach (taps[t]) fb = fb ^ ((v >> (taps[t] - 1)) & 1);
        return ((v << 1) | fb) & ((64'd1 << pw) - 1);
    endfunction

    // Expected operands follow directly from the mode definitions: constants, LFSR sequence, counter, walking one.
    task automatic plan(input int d, input int w, input int lat, input int m, input int n,
                        input bit inj, input int s0);
        longint mask, lf, a, b, v, p;
        exp_t   e;
        mask = (64'd1 << w) - 1;
        lf   = 64'hACE1 & ((64'd1 << (2 * w)) - 1);
        exp_err[d] = 0;
        exp_fa[d]  = 0;
        exp_fb[d]  = 0;
        for (int i = 0; i < n; i++) begin
            case (m)
                0: begin a = mask; b = mask; end
                1: begin a = lf >> w; b = lf & mask; lf = lfsr_step(lf, 2 * w); end
                2: begin v = longint'(i) % (64'd1 << (2 * w)); a = v >> w; b = v & mask; end
                default: begin a = 64'd1 << (i % w); b = mask; end
            endcase
            p   = a * b;
            e.s = p ^ longint'(inj);
            e.c = s0 + 1 + i + lat;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
            if (inj) begin
                if (exp_err[d] == 0) begin
                    exp_fa[d] = a;
                    exp_fb[d] = b;
                end
                if (exp_err[d] < 65535) exp_err[d]++;
            end
            last_s[d] = e.s;
        end
    endtask

    task automatic launch(input int m, input int n, input bit inj);
        int s0;
        @(negedge clk);
        mode   = 2'(m);
        num    = CW'(n);
        inject = inj;
        start  = 1'b1;
        s0     = cyc + 1;
        plan(0, W0, P0 + 1, m, n, inj, s0);
        plan(1, W1, P1 + 1, m, n, inj, s0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input int m, input int n, input bit inj, input bit mid);
        int b0, b1, k;
        b0 = 0;
        b1 = 0;
        k  = 0;
        launch(m, n, inj);
        while (!(done0 && done1) && k < n + 40) begin
            if (busy0) b0++;
            if (busy1) b1++;
            if (k == 1) begin
                mode = 2'($urandom);
                num  = CW'($urandom);
            end
            start = mid && (k == 2);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("done0", done0, 1);
        chk("done1", done1, 1);
        chk("busy_cycles0", b0, (n == 0) ? 1 : n + 2 + P0);
        chk("busy_cycles1", b1, (n == 0) ? 1 : n + 2 + P1);
        chk("err_count0", err0, exp_err[0]);
        chk("err_count1", err1, exp_err[1]);
        chk("first_err_a0", fa0, exp_fa[0]);
        chk("first_err_b0", fb0, exp_fb[0]);
        chk("first_err_a1", fa1, exp_fa[1]);
        chk("first_err_b1", fb1, exp_fb[1]);
        chk("pass0", pass0, exp_err[0] == 0);
        chk("pass1", pass1, exp_err[1] == 0);
        chk("pending0", q0.size(), 0);
        chk("pending1", q1.size(), 0);
        chk("held_sum0", sum0, last_s[0]);
        chk("held_sum1", sum1, last_s[1]);
    endtask

    always @(negedge clk) begin
        if (sv0) begin
            chk("sv0_expected", longint'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                chk("sum0", sum0, e0.s);
                chk("lat0", cyc, e0.c);
            end
        end
    end

    always @(negedge clk) begin
        if (sv1) begin
            chk("sv1_expected", longint'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                chk("sum1", sum1, e1.s);
                chk("lat1", cyc, e1.c);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy0"}, busy0, 0);
        chk({tag, "_done0"}, done0, 0);
        chk({tag, "_sv0"}, sv0, 0);
        chk({tag, "_pass0"}, pass0, 0);
        chk({tag, "_sum0"}, sum0, 0);
        chk({tag, "_err0"}, err0, 0);
        chk({tag, "_fa0"}, fa0, 0);
        chk({tag, "_fb0"}, fb0, 0);
        chk({tag, "_busy1"}, busy1, 0);
        chk({tag, "_done1"}, done1, 0);
        chk({tag, "_sv1"}, sv1, 0);
        chk({tag, "_sum1"}, sum1, 0);
        chk({tag, "_err1"}, err1, 0);
    endtask

    initial begin
        last_s[0] = 0;
        last_s[1] = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;

        run(0, 1, 1'b0, 1'b0);
        run(3, 8, 1'b0, 1'b0);
        run(1, 100, 1'b1, 1'b0);
        run(1, 20, 1'b0, 1'b1);
        run(2, 0, 1'b0, 1'b0);

        launch(1, 50, 1'b0);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_zero("midrun_reset");
        q0.delete();
        q1.delete();
        last_s[0] = 0;
        last_s[1] = 0;
        @(negedge clk);
        rst = 1'b1;
        run(1, 50, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++)
            run($urandom_range(0, 3), $urandom_range(1, 60), 1'($urandom_range(0, 1)), 1'b0);

        run(2, 65536, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
